rv32m_coproc: RTL and testbench
===============================

RV32M_COPROC -- requirements
Module: rv32m_coproc

Interface
- REQ-001: Parameter XLEN, default 32; datapath width; only 32 is supported.
- REQ-002: i_clk  input  1  the single clock; all state changes on its rising edge.
- REQ-003: i_rst  input  1  reset, synchronous and active-high.
- REQ-004: i_en  input  1  start request, one-cycle pulse from the execute stage.
- REQ-005: i_rs1  input  XLEN  operand A / dividend; stable while i_en is high.
- REQ-006: i_rs2  input  XLEN  operand B / divisor; stable while i_en is high.
- REQ-007: i_f3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- REQ-008: o_res  output  XLEN  registered result; valid when o_ack is high.
- REQ-009: o_ack  output  1  registered completion strobe, high for exactly one cycle per accepted request.
- REQ-010: o_busy  output  1  high whenever the state is not IDLE.

Function
- REQ-011: The FSM SHALL have three states: IDLE, CALC and DONE.
- REQ-012: The edge that samples i_en=1 in IDLE is E0; Ek is the k-th rising edge after E0.
- REQ-013: At E0 the block SHALL latch i_f3, the operand magnitudes and the sign flags, clear the 5-bit iteration counter, and enter CALC.
- REQ-014: Signedness: MULH and DIV/REM treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MUL, MULHU and DIVU/REMU are unsigned. MUL low word is sign-agnostic.
- REQ-015: Multiply SHALL be iterative shift-add on magnitudes, 1 bit per cycle, with a 2*XLEN product register.
- REQ-016: Divide SHALL be iterative restoring division on magnitudes, 1 quotient bit per cycle.
- REQ-017: Iterations SHALL occur on E1..E32. At E33 the block SHALL apply two's-complement sign correction, register o_res, set o_ack=1 and enter DONE.
- REQ-018: Sign rules: the product is negated if operand signs differ; the quotient is negated if signs differ; the remainder takes the dividend's sign.
- REQ-019: Result select: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32]; DIV/DIVU return the quotient; REM/REMU return the remainder.
- REQ-020: Special cases SHALL be detected in the first CALC cycle and complete at E1 with no iterations:
  - divide-by-zero (DIV/DIVU/REM/REMU, rs2=0): quotient = 0xFFFFFFFF, remainder = rs1.
  - signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- REQ-021: DONE SHALL last exactly one cycle, with o_ack=1, then return to IDLE with o_ack=0.
- REQ-022: i_en SHALL be ignored in CALC and DONE; no request is queued.
- REQ-023: A request SHALL be accepted in the first IDLE cycle after DONE, giving a back-to-back throughput of one op per 35 cycles (normal ops).
- REQ-024: o_res SHALL hold its last value from the ack cycle until the next completion.
- REQ-025: Operand changes after E0 SHALL NOT affect the result.
- REQ-026: The counter SHALL NOT wrap within an operation; leaving CALC is decided at count=31 on E32.

Reset
- REQ-027: i_rst=1 at any edge SHALL force state=IDLE, o_ack=0, o_res=0, o_busy=0, counter=0, and clear the product, remainder and quotient registers.
- REQ-028: Reset mid-operation SHALL abort the operation silently; no o_ack is produced for the aborted request.
- REQ-029: i_en sampled in the same cycle as i_rst=1 SHALL be ignored.

Verification
- REQ-030: MUL, rs1=7, rs2=0xFFFFFFFD -> o_res=0xFFFFFFEB and o_ack high for the single cycle following E33; o_busy high from E0 to E34.
- REQ-031: Three requests with rs1=rs2=0xFFFFFFFF -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF.
- REQ-032: Signed divide, rs1=0xFFFFFFF9 (-7), rs2=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- REQ-033: Special cases -> DIVU 5/0 = 0xFFFFFFFF; REMU 5/0 = 5; DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM of the same = 0. Each SHALL ack after E1.
- REQ-034: i_rst pulsed at E10 of a DIV -> no ack, o_res=0; a subsequent MUL 3*4 -> 12 at E33.
- REQ-035: A second i_en at E5, with operands changed, during a MUL 6*7 -> only one ack, o_res=42; a new i_en in the cycle after DONE is accepted.

Source files
------------

// File: rtl/rv32m_coproc.sv
// Iterative RV32M multiply/divide coprocessor: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with sign correction on completion.
module rv32m_coproc #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    output logic [XLEN-1:0] o_res,
    output logic            o_ack,
    output logic            o_busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          f3;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                neg_a, neg_b;
    logic [4:0]          cnt;
    logic                fin;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     rem, quo;

    logic                in_signed_a, in_signed_b, in_neg_a, in_neg_b;
    logic [XLEN-1:0]     in_mag_a, in_mag_b;
    logic                is_div, div_zero, div_ovf, special;
    logic [XLEN:0]       mul_sum, div_shift;
    logic                div_ge;
    logic [XLEN-1:0]     div_sub;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, a_orig, result, special_res;

    // Operand signedness and magnitudes captured on acceptance
    always_comb begin
        in_signed_a = (i_f3 == 3'b001) || (i_f3 == 3'b010) || (i_f3 == 3'b100) || (i_f3 == 3'b110);
        in_signed_b = (i_f3 == 3'b001) || (i_f3 == 3'b100) || (i_f3 == 3'b110);
        in_neg_a    = in_signed_a & i_rs1[XLEN-1];
        in_neg_b    = in_signed_b & i_rs2[XLEN-1];
        in_mag_a    = in_neg_a ? -i_rs1 : i_rs1;
        in_mag_b    = in_neg_b ? -i_rs2 : i_rs2;
    end

    // Datapath steps, special-case detection and final sign correction
    always_comb begin
        is_div    = f3[2];
        div_zero  = is_div && (mag_b == '0);
        div_ovf   = is_div && !f3[0] && neg_a && neg_b &&
                    (mag_a == {1'b1, {(XLEN-1){1'b0}}}) && (mag_b == XLEN'(1));
        special   = (cnt == 5'd0) && !fin && (div_zero || div_ovf);

        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
        div_shift = {rem, quo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        div_sub   = div_shift[XLEN-1:0] - mag_b;

        prod_fix  = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix   = (neg_a ^ neg_b) ? -quo : quo;
        rem_fix   = neg_a ? -rem : rem;
        a_orig    = neg_a ? -mag_a : mag_a;

        result = quo_fix;
        case (f3)
            3'b000:                 result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quo_fix;
            default:                result = rem_fix;
        endcase

        special_res = '1;
        if (div_zero)
            special_res = f3[1] ? a_orig : '1;
        else if (div_ovf)
            special_res = f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = CALC;
            CALC:    if (special || fin) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    // The counter saturates at 31; fin marks that the last iteration has run
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            f3    <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            cnt   <= '0;
            fin   <= 1'b0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            o_res <= '0;
            o_ack <= 1'b0;
        end else begin
            state <= state_nxt;
            o_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        f3    <= i_f3;
                        mag_a <= in_mag_a;
                        mag_b <= in_mag_b;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        cnt   <= '0;
                        fin   <= 1'b0;
                        prod  <= {{XLEN{1'b0}}, in_mag_b};
                        rem   <= '0;
                        quo   <= in_mag_a;
                    end
                end
                CALC: begin
                    if (special) begin
                        o_res <= special_res;
                        o_ack <= 1'b1;
                    end else if (fin) begin
                        o_res <= result;
                        o_ack <= 1'b1;
                    end else begin
                        if (is_div) begin
                            rem <= div_ge ? div_sub : div_shift[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], div_ge};
                        end else begin
                            prod <= {mul_sum, prod[XLEN-1:1]};
                        end
                        if (cnt == 5'd31)
                            fin <= 1'b1;
                        else
                            cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_coproc.sv
// Self-checking bench for rv32m_coproc: directed RV32M cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_rv32m_coproc;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [31:0] i_rs1, i_rs2;
    logic [2:0]  i_f3;
    logic [31:0] o_res;
    logic        o_ack, o_busy;

    int checks = 0;
    int passes = 0;

    always #5 i_clk = ~i_clk;

    rv32m_coproc #(.XLEN(32)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_rs1 (i_rs1),
        .i_rs2 (i_rs2),
        .i_f3  (i_f3),
        .o_res (o_res),
        .o_ack (o_ack),
        .o_busy(o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference result straight from RV32M arithmetic rules
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = '0;
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; p = q; return p[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; p = q; return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'h0)) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    // Called at a falling edge; the next rising edge is E0
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        i_f3  = f3;
        i_rs1 = a;
        i_rs2 = b;
        i_en  = 1'b1;
        @(negedge i_clk);
    endtask

    // Waits for the ack with a bounded budget, scrambling operands meanwhile;
    // poke_at > 0 raises a second i_en sampled at E<poke_at>
    task automatic checkOutput(input logic [31:0] exp, input int exp_lat, input string tag, input int poke_at);
        int lat     = 0;
        bit seen    = 1'b0;
        bit busy_ok = 1'b1;
        while (lat < 40 && !seen) begin
            i_en  = (poke_at != 0 && lat == poke_at - 1);
            i_rs1 = $urandom;
            i_rs2 = $urandom;
            i_f3  = 3'($urandom_range(0, 7));
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge i_clk);
            lat++;
            if (o_ack === 1'b1) seen = 1'b1;
        end
        i_en = 1'b0;
        check({tag, " ack_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, o_res, exp);
        check({tag, " busy_during_op"}, 32'(busy_ok & o_busy), 32'd1);
        @(negedge i_clk);
        check({tag, " ack_one_cycle"}, 32'(o_ack), 32'd0);
        check({tag, " idle_after_done"}, 32'(o_busy), 32'd0);
        check({tag, " result_held"}, o_res, exp);
    endtask

    task automatic watchNoAck(input string tag, input int cycles);
        bit acked = 1'b0;
        bit busy  = 1'b0;
        repeat (cycles) begin
            @(negedge i_clk);
            if (o_ack !== 1'b0) acked = 1'b1;
            if (o_busy !== 1'b0) busy = 1'b1;
        end
        check({tag, " no_ack"}, 32'(acked), 32'd0);
        check({tag, " stays_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] corner [5];
        logic [31:0] a, b;
        logic [2:0]  f;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;

        $display("[TB] reset with i_en held high");
        i_rst = 1'b1; i_en = 1'b1; i_f3 = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd5;
        repeat (3) @(negedge i_clk);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset ack", 32'(o_ack), 32'd0);
        check("reset res", o_res, 32'd0);
        i_rst = 1'b0; i_en = 1'b0;
        @(negedge i_clk);
        check("post_reset idle", 32'(o_busy), 32'd0);

        $display("[TB] directed multiply cases");
        applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD);
        checkOutput(32'hFFFFFFEB, 33, "mul_7xm3", 0);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput(32'hFFFFFFFE, 33, "mulhu_ff", 0);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput(32'h00000000, 33, "mulh_ff", 0);
        applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput(32'hFFFFFFFF, 33, "mulhsu_ff", 0);

        $display("[TB] directed divide cases");
        applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2);
        checkOutput(32'hFFFFFFFD, 33, "div_m7_2", 0);
        applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2);
        checkOutput(32'hFFFFFFFF, 33, "rem_m7_2", 0);
        applyStimulus(3'd5, 32'd100, 32'd7);
        checkOutput(32'd14, 33, "divu_100_7", 0);
        applyStimulus(3'd7, 32'd100, 32'd7);
        checkOutput(32'd2, 33, "remu_100_7", 0);

        $display("[TB] divide special cases");
        applyStimulus(3'd5, 32'd5, 32'd0);
        checkOutput(32'hFFFFFFFF, 1, "divu_by0", 0);
        applyStimulus(3'd7, 32'd5, 32'd0);
        checkOutput(32'd5, 1, "remu_by0", 0);
        applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF);
        checkOutput(32'h80000000, 1, "div_ovf", 0);
        applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF);
        checkOutput(32'h00000000, 1, "rem_ovf", 0);

        $display("[TB] reset in the middle of a divide");
        applyStimulus(3'd4, 32'd100, 32'd7);
        i_en = 1'b0;
        repeat (9) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort res", o_res, 32'd0);
        watchNoAck("abort", 40);
        applyStimulus(3'd0, 32'd3, 32'd4);
        checkOutput(32'd12, 33, "mul_3x4", 0);

        $display("[TB] second request while busy is dropped");
        applyStimulus(3'd0, 32'd6, 32'd7);
        checkOutput(32'd42, 33, "mul_6x7_poke", 5);
        watchNoAck("poke", 40);

        $display("[TB] randomized back-to-back operations");
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            if (f[2] && $urandom_range(0, 7) == 0) b = 32'h0;
            if (f[2] && $urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 255));
            applyStimulus(f, a, b);
            checkOutput(ref_model(f, a, b), ref_latency(f, a, b), $sformatf("rand%0d_f%0d", n, f), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
